// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt sequencer for the 4-bit LED CPU.
// Conditions the three board buttons, derives a run tick from a free-running
// prescaler and issues a one-cycle cpu_en strobe per instruction. After every
// instruction the program counter is checked for a breakpoint or a jump-to-self.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RST_HOLD | cpu_rst asserted, hold counter running, then HALT
// HALT     | idle, waiting for a run or step press
// RUN      | free running, one instruction per prescaler tick
// EXEC     | cpu_en high for exactly one cycle, adr_prev captured
// CHECK    | adr reflects the executed instruction; decide halt or resume
module cpu_run_ctrl #(
  parameter int TICK_BASE       = 12,
  parameter int DB_CYCLES       = 65535,
  parameter int RST_HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       btn_rst,
  input  logic [1:0] speed,
  input  logic [3:0] adr,
  input  logic       bp_en,
  input  logic [3:0] bp_adr,
  output logic       cpu_en,
  output logic       cpu_rst,
  output logic [2:0] state,
  output logic       halted,
  output logic [7:0] step_count
);

  localparam int PW  = TICK_BASE + 12;
  // Debounce counter counts 0 .. DB_CYCLES-1; the level flips on the cycle
  // that would make it reach DB_CYCLES.
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam int HW  = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

  localparam int B_RUN  = 0;
  localparam int B_STEP = 1;
  localparam int B_RST  = 2;

  typedef enum logic [2:0] {
    S_RST_HOLD = 3'd0,
    S_HALT     = 3'd1,
    S_RUN      = 3'd2,
    S_EXEC     = 3'd3,
    S_CHECK    = 3'd4
  } state_t;

  // button conditioning
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     db_lvl_q, db_lvl_d;
  logic [DBW-1:0] db_cnt_q [3];
  logic [DBW-1:0] db_cnt_d [3];
  logic [2:0]     press_q, press_d;

  // prescaler
  logic [PW-1:0]  presc_q, presc_d;
  logic [PW-1:0]  tick_mask;
  logic           tick;

  // sequencer
  state_t         state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [7:0]     step_cnt_q, step_cnt_d;
  logic           halted_q, halted_d;
  logic           pause_q, pause_d;
  logic           run_mode_q, run_mode_d;
  logic [3:0]     adr_prev_q, adr_prev_d;

  logic           run_press, step_press, rst_press;

  // Debounce: the level follows the synchronized input only after it has
  // disagreed for DB_CYCLES consecutive cycles; a rising flip is a press.
  always_comb begin
    db_lvl_d = db_lvl_q;
    press_d  = '0;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_lvl_d[i] = sync2_q[i];
          press_d[i]  = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Prescaler increment and speed-dependent tick compare on the low bits.
  always_comb begin
    presc_d   = presc_q + 1'b1;
    tick_mask = ~({PW{1'b1}} << (TICK_BASE + 4 * int'(speed)));
    tick      = ((presc_q & tick_mask) == '0);
  end

  // Synchronizers, debouncers and prescaler registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_lvl_q <= '0;
      press_q  <= '0;
      presc_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= {btn_rst, btn_step, btn_run};
      sync2_q  <= sync1_q;
      db_lvl_q <= db_lvl_d;
      press_q  <= press_d;
      presc_q  <= presc_d;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign run_press  = press_q[B_RUN];
  assign step_press = press_q[B_STEP];
  assign rst_press  = press_q[B_RST];

  // Sequencer next-state logic; a soft-reset press overrides every state.
  always_comb begin
    state_d    = state_q;
    hold_d     = '0;
    step_cnt_d = step_cnt_q;
    halted_d   = halted_q;
    pause_d    = pause_q;
    run_mode_d = run_mode_q;
    adr_prev_d = adr_prev_q;

    unique case (state_q)
      S_RST_HOLD: begin
        step_cnt_d = '0;
        halted_d   = 1'b0;
        pause_d    = 1'b0;
        if (hold_q == HOLD_LAST) begin
          state_d = S_HALT;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_HALT: begin
        pause_d = 1'b0;
        if (run_press) begin
          state_d  = S_RUN;
          halted_d = 1'b0;
        end else if (step_press) begin
          state_d    = S_EXEC;
          run_mode_d = 1'b0;
          halted_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (run_press) begin
          state_d = S_HALT;
        end else if (tick) begin
          state_d    = S_EXEC;
          run_mode_d = 1'b1;
        end
      end
      S_EXEC: begin
        adr_prev_d = adr;
        step_cnt_d = step_cnt_q + 8'd1;
        state_d    = S_CHECK;
        if (run_press) begin
          pause_d = 1'b1;
        end
      end
      S_CHECK: begin
        // A run press arriving in CHECK itself is treated as a pause request
        // consumed right here, so it never lingers into a later run.
        pause_d = 1'b0;
        if (adr == adr_prev_q) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (bp_en && (adr == bp_adr)) begin
          state_d = S_HALT;
        end else if (pause_q || run_press) begin
          state_d = S_HALT;
        end else if (run_mode_q) begin
          state_d = S_RUN;
        end else begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d = S_RST_HOLD;
      end
    endcase

    if (rst_press) begin
      state_d    = S_RST_HOLD;
      hold_d     = '0;
      step_cnt_d = '0;
      halted_d   = 1'b0;
      pause_d    = 1'b0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RST_HOLD;
      hold_q     <= '0;
      step_cnt_q <= '0;
      halted_q   <= 1'b0;
      pause_q    <= 1'b0;
      run_mode_q <= 1'b0;
      adr_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      step_cnt_q <= step_cnt_d;
      halted_q   <= halted_d;
      pause_q    <= pause_d;
      run_mode_q <= run_mode_d;
      adr_prev_q <= adr_prev_d;
    end
  end

  assign cpu_en     = (state_q == S_EXEC);
  assign cpu_rst    = (state_q == S_RST_HOLD);
  assign state      = state_q;
  assign halted     = halted_q;
  assign step_count = step_cnt_q;

endmodule
